// File: rtl/lsu_rmw_ctrl.sv
// Load/store controller in front of a word-only data memory. Sub-word stores are
// done as read-merge-write; loads get lane extraction and sign/zero extension.
module lsu_rmw_ctrl #(
    parameter  int MEM_DEPTH = 32,
    localparam int AW        = $clog2(MEM_DEPTH) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          mem_re,
    output logic [AW-3:0] mem_rd_addr,
    input  logic [31:0]   mem_rd_data,
    output logic          mem_we,
    output logic [AW-3:0] mem_wr_addr,
    output logic [31:0]   mem_wr_data
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WR, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q;
    logic [2:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;   // store data; replaced by the merged word for sub-word stores
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          req_err;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    assign accept = req_valid && req_ready;

    // Unsigned flag only matters for loads; an unsigned word load is illegal.
    always_comb begin
        req_err = 1'b0;
        case (req_size[1:0])
            2'b11:   req_err = 1'b1;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00) || (!req_we && req_size[2]);
            default: req_err = 1'b0;
        endcase
    end

    always_comb begin
        shifted  = mem_rd_data >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        case (size_q[1:0])
            2'b00:   load_ext = {{24{~size_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~size_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        merged = mem_rd_data;
        case (size_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                              state_d = RESP;
                    else if (req_we && req_size[1:0] == 2'b10) state_d = WR;
                    else                                      state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA:  state_d = we_q ? WR : RESP;
            WR:       state_d = RESP;
            RESP:     state_d = rsp_ready ? IDLE : RESP;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        rdata_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (we_q) wdata_q <= merged;
                    else      rdata_q <= load_ext;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign mem_re      = (state_q == RD_ISSUE);
    assign mem_rd_addr = addr_q[AW-1:2];
    assign mem_we      = (state_q == WR);
    assign mem_wr_addr = addr_q[AW-1:2];
    assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Bench for lsu_rmw_ctrl: word memory model, vector table through a scoreboard,
// plus hand sequences for response stall and reset in the middle of an RMW.
module tb_lsu_rmw_ctrl;
    localparam int MEM_DEPTH = 32;
    localparam int AW        = $clog2(MEM_DEPTH) + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_re, mem_we;
    logic [AW-3:0] mem_rd_addr, mem_wr_addr;
    logic [31:0]   mem_rd_data, mem_wr_data;

    always #5 clk = ~clk;

    lsu_rmw_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_re(mem_re), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    // Memory model; the preload port lets the bench seed words without a second driver.
    logic [31:0]   mem [MEM_DEPTH];
    logic          pre_we;
    logic [AW-3:0] pre_addr;
    logic [31:0]   pre_data;
    always @(posedge clk) begin
        if (mem_re) mem_rd_data <= mem[mem_rd_addr];
        if (mem_we) mem[mem_wr_addr] <= mem_wr_data;
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    typedef struct {
        logic          we;
        logic [2:0]    size;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        int            re_at;   // 0 = must not occur
        int            we_at;
        logic [AW-3:0] wa;
        logic [31:0]   wd;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[20];

    function automatic vec_t mk(logic we, logic [2:0] size, logic [AW-1:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic err, int lat, int re_at, int we_at,
                                logic [AW-3:0] wa, logic [31:0] wd);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
        v.lat = lat; v.re_at = re_at; v.we_at = we_at; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-3:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Issue one request, trace memory activity per cycle, then check against the popped entry.
    task automatic run(input vec_t v);
        vec_t          e;
        int            n, re_at, we_at;
        logic [AW-3:0] wa;
        logic [31:0]   wd;
        bit            got;
        sb.push_back(v);
        drive(v);
        n = 1; re_at = 0; we_at = 0; wa = '0; wd = '0; got = 1'b0;
        while (n <= 20 && !got) begin
            if (mem_re) re_at = n;
            if (mem_we) begin we_at = n; wa = mem_wr_addr; wd = mem_wr_data; end
            if (rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        e = sb.pop_front();
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one at addr 0x%02h", e.addr);
        end else begin
            chk("latency", n, e.lat);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("mem_re_cycle", re_at, e.re_at);
            chk("mem_we_cycle", we_at, e.we_at);
            if (e.we_at != 0) begin
                chk("mem_wr_addr", 32'(wa), 32'(e.wa));
                chk("mem_wr_data", wd, e.wd);
            end
        end
        @(posedge clk); #1;
    endtask

    // Structural invariants every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ((mem_re && mem_we) || (rsp_valid && req_ready)) begin
                errors++;
                $display("FAIL exclusive: got re=%0b we=%0b rv=%0b rr=%0b expected no overlap",
                         mem_re, mem_we, rsp_valid, req_ready);
            end
        end
    end

    initial begin
        vec_t v;
        int   n;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        preload(5'd3, 32'h8899AABB);
        preload(5'd4, 32'h0);
        preload(5'd5, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        //             we    size    addr     wdata          rdata         err lat re we wa     wd
        tbl[0]  = mk(1'b0, 3'b000, 7'h0D, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[1]  = mk(1'b0, 3'b100, 7'h0D, 32'h0,        32'h000000AA, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[2]  = mk(1'b1, 3'b001, 7'h0E, 32'hABCD1234, 32'h0,        1'b0, 4, 1, 3, 5'd3, 32'h1234AABB);
        tbl[3]  = mk(1'b0, 3'b010, 7'h0C, 32'h0,        32'h1234AABB, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[4]  = mk(1'b1, 3'b010, 7'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 5'd4, 32'hDEADBEEF);
        tbl[5]  = mk(1'b0, 3'b001, 7'h05, 32'h0,        32'h0,        1'b1, 1, 0, 0, 5'd0, 32'h0);
        tbl[6]  = mk(1'b0, 3'b010, 7'h06, 32'h0,        32'h0,        1'b1, 1, 0, 0, 5'd0, 32'h0);
        tbl[7]  = mk(1'b0, 3'b011, 7'h00, 32'h0,        32'h0,        1'b1, 1, 0, 0, 5'd0, 32'h0);
        tbl[8]  = mk(1'b1, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 5'd0, 32'h0);
        tbl[9]  = mk(1'b0, 3'b110, 7'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0, 5'd0, 32'h0);
        tbl[10] = mk(1'b1, 3'b110, 7'h14, 32'hCAFEF00D, 32'h0,        1'b0, 2, 0, 1, 5'd5, 32'hCAFEF00D);
        tbl[11] = mk(1'b0, 3'b010, 7'h14, 32'h0,        32'hCAFEF00D, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[12] = mk(1'b1, 3'b000, 7'h13, 32'hFFFFFF5A, 32'h0,        1'b0, 4, 1, 3, 5'd4, 32'h5AADBEEF);
        tbl[13] = mk(1'b0, 3'b001, 7'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[14] = mk(1'b0, 3'b101, 7'h12, 32'h0,        32'h00005AAD, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[15] = mk(1'b1, 3'b001, 7'h0C, 32'hABCD7777, 32'h0,        1'b0, 4, 1, 3, 5'd3, 32'h12347777);
        tbl[16] = mk(1'b0, 3'b100, 7'h0F, 32'h0,        32'h00000012, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[17] = mk(1'b0, 3'b000, 7'h0E, 32'h0,        32'h00000034, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        tbl[18] = mk(1'b1, 3'b001, 7'h0D, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 5'd0, 32'h0);
        tbl[19] = mk(1'b0, 3'b010, 7'h0C, 32'h0,        32'h12347777, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        for (int i = 0; i < 20; i++) run(tbl[i]);

        // Response stall: hold rsp_ready low for five cycles once the load completes.
        rsp_ready = 1'b0;
        v = mk(1'b0, 3'b000, 7'h13, 32'h0, 32'h0000005A, 1'b0, 3, 1, 0, 5'd0, 32'h0);
        sb.push_back(v);
        drive(v);
        n = 1;
        while (n <= 20 && !rsp_valid) begin @(posedge clk); #1; n++; end
        v = sb.pop_front();
        chk("stall_latency", n, v.lat);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_rdata", rsp_rdata, v.rdata);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_mem_idle", 32'(mem_re | mem_we), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        run(mk(1'b0, 3'b010, 7'h10, 32'h0, 32'h5AADBEEF, 1'b0, 3, 1, 0, 5'd0, 32'h0));

        // Reset while a byte store sits in RD_DATA: the write and response must vanish.
        v = mk(1'b1, 3'b000, 7'h0C, 32'h00000011, 32'h0, 1'b0, 4, 1, 3, 5'd3, 32'h12347711);
        drive(v);
        chk("rmw_rd_issue", 32'(mem_re), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_mem_we", 32'(mem_we), 32'd0);
            chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_word3", mem[3], 32'h12347777);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        run(mk(1'b0, 3'b010, 7'h0C, 32'h0, 32'h12347777, 1'b0, 3, 1, 0, 5'd0, 32'h0));
        chk("sb_empty", sb.size(), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_rmw_ctrl.md
Name: lsu_rmw_ctrl

Overview:
- Load/store controller directly upstream of the word-organised data memory.
- Accepts one byte, halfword or word load/store per handshake from the MEM pipeline stage.
- Sub-word stores become a read-modify-write (read, merge, full-word write), because the memory has no byte enables.
- Loads get lane extraction and sign/zero extension; misaligned and illegal accesses are trapped.

Parameters:
- MEM_DEPTH, 32, number of 32-bit words in the data memory.
- AW, $clog2(MEM_DEPTH)+2, byte-address width (derived; not to be overridden).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 illegal; [2]: unsigned load.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal access; no memory write performed.
- mem_re  out  1  memory read enable.
- mem_rd_addr  out  AW-2  word index.
- mem_rd_data  in  32  read word, valid the cycle after mem_re.
- mem_we  out  1  memory write enable.
- mem_wr_addr  out  AW-2  word index.
- mem_wr_data  out  32  full merged word.

Behaviour:
- States: IDLE, RD_ISSUE, RD_DATA, WR, RESP.
- On acceptance, req_* are captured into internal registers. All memory and response outputs derive only from state and captured registers; no combinational path from req_* to mem_*.
- req_ready = 1 only in IDLE, so at most one access is outstanding.
- Error check at acceptance:
  - size 11 → error.
  - Store with size[2] set → size[2] ignored.
  - Load size 110 → error.
  - Half with addr[0] ≠ 0 → error.
  - Word with addr[1:0] ≠ 0 → error.
- Transitions from IDLE on acceptance:
  - Error → RESP, rsp_err = 1.
  - Load or sub-word store → RD_ISSUE.
  - Word store → WR.
- RD_ISSUE:
  - mem_re = 1, mem_rd_addr = addr[AW-1:2].
  - → RD_DATA.
- RD_DATA, load:
  - rsp_rdata is registered from mem_rd_data >> (8*addr[1:0]).
  - Byte result: sign- or zero-extended from bit 7. Half result: from bit 15.
  - → RESP.
- RD_DATA, sub-word store:
  - Register the merged word: read word with only the target lane replaced.
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes addr[1] ← wdata[15:0].
  - → WR.
- WR:
  - mem_we = 1 for exactly one cycle.
  - mem_wr_addr = word index.
  - mem_wr_data = merged word (sub-word store) or wdata (word store).
  - → RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable.
  - Stays until rsp_ready; then → IDLE.
  - rsp_valid and req_ready are never high in the same cycle.
- Latency from accept cycle T, with rsp_ready held high:
  - Error: rsp_valid at T+1.
  - Word store: mem_we at T+1, rsp_valid at T+2.
  - Load: rsp_valid at T+3.
  - Sub-word store: mem_we at T+3, rsp_valid at T+4.
- mem_re and mem_we are never asserted in the same cycle.
- mem_re is asserted only in RD_ISSUE; mem_we only in WR.
- Reset (asserted at any time, including mid-RMW):
  - State → IDLE immediately.
  - mem_re, mem_we, rsp_valid, rsp_err = 0; rsp_rdata = 0; all captured registers = 0; req_ready = 1.
  - A write not yet clocked in WR is dropped; memory content is otherwise untouched.
  - No response is produced for the aborted request.
- rsp_ready low in RESP: stall indefinitely; no memory activity while stalled.

Test Plan:
1. Preload word 3 = 0x8899AABB. Load byte, signed, addr 0x0D → rsp_rdata 0xFFFFFFAA at T+3, rsp_err 0. Same access with unsigned → 0x000000AA.
2. Word 3 = 0x8899AABB. Store half 0x1234 to addr 0x0E → mem_re at T+1, mem_we at T+3 with data 0x1234AABB, rsp_valid at T+4. Then load word 0x0C → 0x1234AABB.
3. Store word 0xDEADBEEF to addr 0x10 → mem_we at T+1, mem_wr_addr 4, rsp_valid at T+2. mem_re never asserted.
4. Load half addr 0x05, load word addr 0x06, and size 11 at addr 0x00 → each gives rsp_err 1 at T+1, rsp_rdata 0, no mem_re and no mem_we.
5. Hold rsp_ready low for 5 cycles after a load → rsp_valid and rsp_rdata stable, req_ready 0, no mem_re or mem_we. Release → IDLE the next cycle, and a back-to-back request is accepted.
6. Assert rst during RD_DATA of a byte store → mem_we never asserted, target word unchanged, no response. After release: req_ready 1, and a fresh load returns the original data.
